// File: rtl/window3x3_ctrl.sv
// Sequencing controller for the 3x3 line-buffer window datapath: locks frame
// geometry, tracks pixel row/column, flags interior windows and frame events.
module window3x3_ctrl #(
  parameter int CW   = 11,
  parameter int W_LO = 640,
  parameter int H_LO = 480,
  parameter int W_HI = 1280,
  parameter int H_HI = 720
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tvalid,
  input  logic          in_v_sync,
  input  logic          in_h_sync,
  input  logic          in_data_en,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  output logic [1:0]    res_sel,
  output logic          res_locked,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          win_valid,
  output logic          frame_start,
  output logic          frame_done,
  output logic          geom_err,
  output logic          busy
);

  localparam logic [CW-1:0] W_LO_C = CW'(W_LO);
  localparam logic [CW-1:0] H_LO_C = CW'(H_LO);
  localparam logic [CW-1:0] W_HI_C = CW'(W_HI);
  localparam logic [CW-1:0] H_HI_C = CW'(H_HI);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] TWO_C  = CW'(2);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          vs_q, de_q;
  logic [CW-1:0] wm1_q, wm1_d, hm1_q, hm1_d;
  logic [CW-1:0] pc_q, pc_d, pr_q, pr_d, len_q, len_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [1:0]    res_sel_q, res_sel_d;
  logic          locked_q, locked_d, win_q, win_d, fs_q, fs_d, fd_q, fd_d;
  logic          err_q, err_d, busy_q, busy_d;

  logic vs_rise, vs_fall, de_fall, cfg_lo, cfg_hi, pixel, col_end, row_end, last_px;
  logic h_sync_unused;

  // Line sync carries no sequencing information here; it is monitored only.
  assign h_sync_unused = in_h_sync;

  assign vs_rise = in_v_sync & ~vs_q;
  assign vs_fall = ~in_v_sync & vs_q;
  assign de_fall = ~in_data_en & de_q;
  assign cfg_lo  = (cfg_width == W_LO_C) && (cfg_height == H_LO_C);
  assign cfg_hi  = (cfg_width == W_HI_C) && (cfg_height == H_HI_C);
  assign pixel   = (state_q == S_ACTIVE) && in_data_en;
  assign col_end = (pc_q == wm1_q);
  assign row_end = (pr_q == hm1_q);
  assign last_px = pixel && col_end && row_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state_q <= S_IDLE;
    else if (tvalid) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_lo || cfg_hi) state_d = S_ARMED;
      S_ARMED:  if (vs_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (!vs_rise && (last_px || vs_fall)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its register value, so no branch below can infer a latch.
    wm1_d     = wm1_q;
    hm1_d     = hm1_q;
    pc_d      = pc_q;
    pr_d      = pr_q;
    len_d     = len_q;
    col_d     = col_q;
    row_d     = row_q;
    res_sel_d = res_sel_q;
    locked_d  = locked_q;
    win_d     = win_q;
    err_d     = err_q;
    busy_d    = busy_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        res_sel_d = 2'b00;
        if (cfg_lo) begin
          res_sel_d = 2'b01;
          wm1_d     = W_LO_C - ONE_C;
          hm1_d     = H_LO_C - ONE_C;
        end else if (cfg_hi) begin
          res_sel_d = 2'b10;
          wm1_d     = W_HI_C - ONE_C;
          hm1_d     = H_HI_C - ONE_C;
        end
      end
      S_ARMED: begin
        if (vs_rise) begin
          fs_d     = 1'b1;
          locked_d = 1'b1;
          busy_d   = 1'b1;
          win_d    = 1'b0;
          pc_d     = '0;
          pr_d     = '0;
          col_d    = '0;
          row_d    = '0;
          len_d    = '0;
        end
      end
      S_ACTIVE: begin
        win_d = 1'b0;
        if (vs_rise) begin
          // A second frame sync mid-frame restarts counting from the top.
          err_d = 1'b1;
          fs_d  = 1'b1;
          pc_d  = '0;
          pr_d  = '0;
          col_d = '0;
          row_d = '0;
          len_d = '0;
        end else begin
          if (pixel) begin
            col_d = pc_q;
            row_d = pr_q;
            win_d = (pr_q >= TWO_C) && (pc_q >= TWO_C);
            len_d = len_q + ONE_C;
            if (col_end) begin
              pc_d = '0;
              if (!row_end) pr_d = pr_q + ONE_C;
            end else begin
              pc_d = pc_q + ONE_C;
            end
          end
          if (de_fall) begin
            if (len_q != wm1_q + ONE_C) err_d = 1'b1;
            len_d = '0;
          end
          // The last pixel wins over a coincident v_sync fall: that is a clean end.
          if (last_px || vs_fall) begin
            fd_d     = 1'b1;
            busy_d   = 1'b0;
            locked_d = 1'b0;
            if (!last_px) err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      wm1_q     <= '0;
      hm1_q     <= '0;
      pc_q      <= '0;
      pr_q      <= '0;
      len_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      res_sel_q <= 2'b00;
      locked_q  <= 1'b0;
      win_q     <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else if (tvalid) begin
      vs_q      <= in_v_sync;
      de_q      <= in_data_en;
      wm1_q     <= wm1_d;
      hm1_q     <= hm1_d;
      pc_q      <= pc_d;
      pr_q      <= pr_d;
      len_q     <= len_d;
      col_q     <= col_d;
      row_q     <= row_d;
      res_sel_q <= res_sel_d;
      locked_q  <= locked_d;
      win_q     <= win_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end else begin
      fs_q <= 1'b0;
      fd_q <= 1'b0;
    end
  end

  assign res_sel     = res_sel_q;
  assign res_locked  = locked_q;
  assign col         = col_q;
  assign row         = row_q;
  assign win_valid   = win_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign geom_err    = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_window3x3_ctrl.sv
// Scoreboard bench for window3x3_ctrl on reduced frame geometries (8x6 and 12x8)
// so that complete frames, stalls and error cases fit in a short run.
module tb_window3x3_ctrl;
  localparam int CW = 11;
  localparam int WL = 8;
  localparam int HL = 6;
  localparam int WH = 12;
  localparam int HH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tvalid = 1'b0;
  logic          in_v_sync = 1'b0;
  logic          in_h_sync = 1'b0;
  logic          in_data_en = 1'b0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_height = '0;
  logic [1:0]    res_sel;
  logic          res_locked, win_valid, frame_start, frame_done, geom_err, busy;
  logic [CW-1:0] col, row;

  window3x3_ctrl #(.CW(CW), .W_LO(WL), .H_LO(HL), .W_HI(WH), .H_HI(HH)) dut (
    .clk(clk), .rst(rst), .tvalid(tvalid), .in_v_sync(in_v_sync), .in_h_sync(in_h_sync),
    .in_data_en(in_data_en), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .res_sel(res_sel), .res_locked(res_locked), .col(col), .row(row),
    .win_valid(win_valid), .frame_start(frame_start), .frame_done(frame_done),
    .geom_err(geom_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            px;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    bit            win, fs, fd, err, lk, bz;
    logic [1:0]    rs;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_fs, n_fd, n_win, m_win;
  bit         m_err = 1'b0;
  logic [1:0] m_rs = 2'b00;
  bit         stall_en = 1'b0;
  bit         acc_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted cycle produces one registered result half a cycle later.
  always @(posedge clk) acc_s = tvalid && !rst;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (acc_s) begin
        if (q.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          if (e.px) begin
            check("row_col", 32'({row, col}), 32'({e.r, e.c}));
            check("win_valid", 32'(win_valid), 32'(e.win));
            if (win_valid) n_win++;
          end
          check("pulses", 32'({frame_start, frame_done}), 32'({e.fs, e.fd}));
          check("flags", 32'({geom_err, res_sel, res_locked, busy}),
                32'({e.err, e.rs, e.lk, e.bz}));
          if (frame_start) n_fs++;
          if (frame_done) n_fd++;
        end
      end else begin
        check("stall_pulse", 32'({frame_start, frame_done}), 32'd0);
      end
    end
  end

  // Drives one accepted cycle (optionally preceded by random stall cycles) and
  // queues the response the geometry rules predict for it.
  task automatic send(input bit vs, input bit de, input bit px, input bit fs, input bit fd,
                      input bit lk, input bit bz, input int k, input int w);
    exp_t e;
    int   n;
    n = 0;
    while (stall_en && n < 6 && $urandom_range(1, 0) == 1) begin
      @(negedge clk);
      tvalid     = 1'b0;
      in_v_sync  = 1'($urandom);
      in_data_en = 1'($urandom);
      in_h_sync  = 1'($urandom);
      n++;
    end
    @(negedge clk);
    tvalid     = 1'b1;
    in_v_sync  = vs;
    in_data_en = de;
    in_h_sync  = !de;
    e.px  = px;
    e.r   = CW'(k / w);
    e.c   = CW'(k % w);
    e.win = px && (k / w >= 2) && (k % w >= 2);
    e.fs  = fs;
    e.fd  = fd;
    e.err = m_err;
    e.lk  = lk;
    e.bz  = bz;
    e.rs  = m_rs;
    if (e.win) m_win++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    tvalid = 1'b0;
    rst    = 1'b1;
    #1;
    check("reset_clears_err", 32'(geom_err), 32'd0);
    m_err = 1'b0;
    m_rs  = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input logic [1:0] code, input bit short_ln,
                       input bit cfg_sw, input bit early, input bit fall_last, input bit abort);
    int k, len, prev_len;
    bit stop, last;
    k = 0; prev_len = w; stop = 1'b0;
    n_fs = 0; n_fd = 0; n_win = 0; m_win = 0;
    cfg_width  = CW'(w);
    cfg_height = CW'(h);
    m_rs       = code;
    repeat (2) send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, w);
    send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, w);
    for (int l = 0; l < h && !stop; l++) begin
      len = w;
      if (short_ln && l == 2) len = w - 1;
      if (short_ln && l == 3) len = w + 1;
      if (l > 0 && prev_len != w) m_err = 1'b1;
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, w);
      if (early && l == 3) begin
        m_err = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, w);
        stop = 1'b1;
      end else begin
        if (cfg_sw && l == h / 2) begin
          cfg_width  = CW'(WH);
          cfg_height = CW'(HH);
        end
        for (int p = 0; p < len; p++) begin
          last = (k == w * h - 1);
          send(!(fall_last && last), 1'b1, 1'b1, 1'b0, last, !last, !last, k, w);
          k++;
          if (abort && l == 1 && p == 3) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("reset_mid_line", 32'({res_sel, res_locked, col, row, win_valid,
                                         frame_start, frame_done, geom_err, busy}), 32'd0);
            q.delete();
            m_err  = 1'b0;
            m_rs   = 2'b00;
            tvalid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
          end
        end
      end
      prev_len = len;
    end
    send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, w);
    idle(2);
    check("frame_start_count", 32'(n_fs), 32'd1);
    check("frame_done_count", 32'(n_fd), 32'd1);
    check("win_count", 32'(n_win), 32'(m_win));
    if (!early) check("win_total", 32'(n_win), 32'((w - 2) * (h - 2)));
  endtask

  initial begin
    int bad_w[3];
    int bad_h[3];
    bad_w[0] = 800; bad_h[0] = 600;
    bad_w[1] = WL;  bad_h[1] = HH;
    bad_w[2] = WH;  bad_h[2] = HL;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", 32'({res_sel, res_locked, col, row, win_valid,
                              frame_start, frame_done, geom_err, busy}), 32'd0);
    rst = 1'b0;

    // Unsupported geometries must leave the block idle, even across a v_sync pulse.
    for (int i = 0; i < 3; i++) begin
      cfg_width  = CW'(bad_w[i]);
      cfg_height = CW'(bad_h[i]);
      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
      send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
      send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    end
    idle(1);

    frame(WL, HL, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(WH, HH, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stall_en = 1'b1;
    frame(WL, HL, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(WH, HH, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stall_en = 1'b0;
    frame(WL, HL, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(WL, HL, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(WL, HL, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("short_line_err_sticky", 32'(geom_err), 32'd1);
    reset_dut();
    frame(WL, HL, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    idle(2);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
